// File: rtl/math_pkg.sv
// Shared constants, stage payload type and parameter helpers for the math utility library.
package math_pkg;

    localparam int MATH_W = 48;

    // One pipeline stage's payload: operands ride along until their segment is consumed.
    typedef struct packed {
        logic [MATH_W-1:0] a;
        logic [MATH_W-1:0] b;
        logic [MATH_W-1:0] d;
        logic              borrow;
    } math_sub_stage_t;

    function automatic int math_seg_w(input int segments);
        return MATH_W / segments;
    endfunction

    function automatic bit math_seg_legal(input int segments);
        return (segments == 1) || (segments == 2) || (segments == 3) ||
               (segments == 4) || (segments == 6);
    endfunction

endpackage

// File: rtl/math_sub_seg.sv
// One borrow-chain segment of the pipelined fabric subtractor: resolves segment SEG_IDX
// and holds the payload until the next stage takes it.
module math_sub_seg
    import math_pkg::*;
#(
    parameter int SEG_W    = 12,
    parameter int SEG_IDX  = 0,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            in_vld,
    input  math_sub_stage_t in_stage,
    input  logic            drain,
    output logic            ready,
    output logic            out_vld,
    output math_sub_stage_t out_stage
);

    localparam int LO = SEG_IDX * SEG_W;

    // a - b - bin computed as a + ~b + !bin; a missing carry out means a borrow.
    function automatic logic [SEG_W:0] seg_sub(
        input logic [SEG_W-1:0] a_seg,
        input logic [SEG_W-1:0] b_seg,
        input logic             bin
    );
        logic [SEG_W:0] sum;
        sum = {1'b0, a_seg} + {1'b0, ~b_seg} + {{SEG_W{1'b0}}, ~bin};
        return {~sum[SEG_W], sum[SEG_W-1:0]};
    endfunction

    logic            vld_p0;
    math_sub_stage_t data_p0;
    logic [SEG_W:0]  seg_res;
    math_sub_stage_t nxt;
    logic            load;

    always_comb begin
        seg_res = seg_sub(in_stage.a[LO +: SEG_W], in_stage.b[LO +: SEG_W], in_stage.borrow);
        nxt = in_stage;
        nxt.d[LO +: SEG_W] = seg_res[SEG_W-1:0];
        nxt.borrow = seg_res[SEG_W];
    end

    assign ready = !vld_p0 || drain;
    assign load  = ena && ready;

    // ---- stage register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            if (CLR_DATA) begin
                data_p0 <= '0;
            end
        end else if (load) begin
            vld_p0 <= in_vld;
            if (in_vld) begin
                data_p0 <= nxt;
            end
        end
    end

    assign out_vld   = vld_p0;
    assign out_stage = data_p0;

endmodule

// File: rtl/math_sub_48.sv
// Pipelined 48-bit unsigned fabric subtractor: dout = {dina < dinb, dina - dinb}, with the
// borrow chain split into SEGMENTS registered segments and a valid/ready handshake.
module math_sub_48
    import math_pkg::*;
#(
    parameter int SEGMENTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [MATH_W-1:0] dina,
    input  logic [MATH_W-1:0] dinb,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [MATH_W:0]   dout
);

    localparam int SEG_W = math_seg_w(SEGMENTS);

    if (!math_seg_legal(SEGMENTS)) begin : g_bad_segments
        $error("math_sub_48: SEGMENTS must be one of 1, 2, 3, 4, 6");
    end

    // Index k feeds stage k; index SEGMENTS is the output register of the last stage.
    math_sub_stage_t stage_p [SEGMENTS+1];
    logic            vld_p   [SEGMENTS+1];
    // accept[k]: stage k takes new contents this cycle (equivalently stage k-1 drains).
    logic            accept  [SEGMENTS+1];

    assign stage_p[0].a      = dina;
    assign stage_p[0].b      = dinb;
    assign stage_p[0].d      = '0;
    assign stage_p[0].borrow = 1'b0;
    assign vld_p[0]          = din_valid;
    assign accept[SEGMENTS]  = dout_ready;

    for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
        math_sub_seg #(
            .SEG_W   (SEG_W),
            .SEG_IDX (k),
            .CLR_DATA(k == SEGMENTS - 1)
        ) u_seg (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .in_vld   (vld_p[k]),
            .in_stage (stage_p[k]),
            .drain    (accept[k+1]),
            .ready    (accept[k]),
            .out_vld  (vld_p[k+1]),
            .out_stage(stage_p[k+1])
        );
    end

    assign din_ready  = ena && !rst && accept[0];
    assign dout_valid = vld_p[SEGMENTS];
    assign dout       = {stage_p[SEGMENTS].borrow, stage_p[SEGMENTS].d};

endmodule

// File: tb/tb_math_sub_48.sv
// Bench for math_sub_48: SEGMENTS = 1, 4 and 6 instances share stimulus, each with its own
// FIFO reference model of {dina < dinb, dina - dinb}.
module tb_math_sub_48;

    logic        clk = 1'b0;
    logic        rst, ena, din_valid, dout_ready;
    logic [47:0] dina, dinb;
    logic        din_ready_w  [3];
    logic        dout_valid_w [3];
    logic [48:0] dout_w       [3];

    int errors = 0;
    int checks = 0;
    int lat_exp [3] = '{1, 4, 6};

    always #5 clk = ~clk;

    math_sub_48 #(.SEGMENTS(1)) u_seg1 (
        .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .din_ready(din_ready_w[0]),
        .dina(dina), .dinb(dinb), .dout_valid(dout_valid_w[0]), .dout_ready(dout_ready),
        .dout(dout_w[0])
    );
    math_sub_48 #(.SEGMENTS(4)) u_seg4 (
        .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .din_ready(din_ready_w[1]),
        .dina(dina), .dinb(dinb), .dout_valid(dout_valid_w[1]), .dout_ready(dout_ready),
        .dout(dout_w[1])
    );
    math_sub_48 #(.SEGMENTS(6)) u_seg6 (
        .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .din_ready(din_ready_w[2]),
        .dina(dina), .dinb(dinb), .dout_valid(dout_valid_w[2]), .dout_ready(dout_ready),
        .dout(dout_w[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    // Reference model: per-instance FIFO of expected results, fed on input transfers.
    logic [48:0] ring [3][64];
    int          wr_ptr  [3] = '{0, 0, 0};
    int          rd_ptr  [3] = '{0, 0, 0};
    int          acc_cnt [3] = '{0, 0, 0};
    logic        prev_rst = 1'b1;
    logic        prev_ena = 1'b1;
    logic        prev_rdy = 1'b0;
    logic        prev_dv   [3];
    logic [48:0] prev_dout [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!prev_rst && (!prev_ena || (prev_dv[i] && !prev_rdy))) begin
                check($sformatf("hold_dout_s%0d", lat_exp[i]), dout_w[i], prev_dout[i]);
                check($sformatf("hold_vld_s%0d", lat_exp[i]), dout_valid_w[i], prev_dv[i]);
            end
            if (!ena) begin
                check($sformatf("ena_low_ready_s%0d", lat_exp[i]), din_ready_w[i], 1'b0);
            end
            if (rst) begin
                wr_ptr[i] = 0;
                rd_ptr[i] = 0;
            end else begin
                if (ena && dout_valid_w[i] && dout_ready) begin
                    check($sformatf("expected_out_s%0d", lat_exp[i]), wr_ptr[i] != rd_ptr[i], 1'b1);
                    if (wr_ptr[i] != rd_ptr[i]) begin
                        check($sformatf("data_s%0d", lat_exp[i]), dout_w[i], ring[i][rd_ptr[i] % 64]);
                        rd_ptr[i]++;
                    end
                end
                if (ena && din_valid && din_ready_w[i]) begin
                    ring[i][wr_ptr[i] % 64] = {dina < dinb, dina - dinb};
                    wr_ptr[i]++;
                    acc_cnt[i]++;
                end
            end
            prev_dv[i]   = dout_valid_w[i];
            prev_dout[i] = dout_w[i];
        end
        prev_rst = rst;
        prev_ena = ena;
        prev_rdy = dout_ready;
    end

    // Single operation into an idle pipeline; checks value, latency and one-cycle valid.
    task automatic lat_test(input string tag, input logic [47:0] a, input logic [47:0] b,
                            input logic [48:0] exp);
        int lat [3];
        int hi  [3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            hi[i]  = 0;
        end
        din_valid = 1'b1;
        dina = a;
        dinb = b;
        step();
        din_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (dout_valid_w[i]) begin
                    if (lat[i] == 0) begin
                        lat[i] = n;
                        check($sformatf("%s_value_s%0d", tag, lat_exp[i]), dout_w[i], exp);
                    end
                    hi[i]++;
                end
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_latency_s%0d", tag, lat_exp[i]), lat[i], lat_exp[i]);
            check($sformatf("%s_vld_cycles_s%0d", tag, lat_exp[i]), hi[i], 1);
        end
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_drained_s%0d", tag, lat_exp[i]), rd_ptr[i], wr_ptr[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base [3];
        logic [48:0] held;

        rst = 1'b1;
        ena = 1'b1;
        din_valid = 1'b0;
        dout_ready = 1'b1;
        dina = '0;
        dinb = '0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_dout_valid_s%0d", lat_exp[i]), dout_valid_w[i], 1'b0);
            check($sformatf("rst_dout_s%0d", lat_exp[i]), dout_w[i], 49'h0);
            check($sformatf("rst_din_ready_s%0d", lat_exp[i]), din_ready_w[i], 1'b0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_rst_ready_s%0d", lat_exp[i]), din_ready_w[i], 1'b1);
        end

        lat_test("single", 48'h0000_0000_0005, 48'h0000_0000_0003, 49'h0_0000_0000_0002);
        lat_test("borrow_all", 48'h0000_0000_0000, 48'h0000_0000_0001, 49'h1_FFFF_FFFF_FFFF);
        lat_test("borrow_mid", 48'h0000_0100_0000, 48'h0000_0000_0001, 49'h0_0000_00FF_FFFF);

        // Back-to-back random stream with the output always ready.
        for (int i = 0; i < 3; i++) base[i] = acc_cnt[i];
        din_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            dina = rnd48();
            dinb = (k % 10 == 0) ? dina : rnd48();
            step();
        end
        din_valid = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stream_accepted_s%0d", lat_exp[i]), acc_cnt[i] - base[i], 100);
        end
        check_drained("stream");

        // Backpressure: output blocked while the source keeps offering data.
        for (int i = 0; i < 3; i++) base[i] = acc_cnt[i];
        held = '0;
        dout_ready = 1'b0;
        din_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            dina = rnd48();
            dinb = rnd48();
            step();
            if (k == 4) held = dout_w[1];
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_accepted_s%0d", lat_exp[i]), acc_cnt[i] - base[i], lat_exp[i]);
            check($sformatf("bp_ready_low_s%0d", lat_exp[i]), din_ready_w[i], 1'b0);
        end
        check("bp_dout_stable_s4", dout_w[1], held);
        din_valid = 1'b0;
        dout_ready = 1'b1;
        repeat (10) step();
        check_drained("bp");

        // Random enable, valid and ready.
        for (int k = 0; k < 400; k++) begin
            ena        = ($urandom_range(0, 3) != 0);
            din_valid  = 1'($urandom_range(0, 1));
            dout_ready = ($urandom_range(0, 3) != 0);
            dina = rnd48();
            dinb = (k % 7 == 0) ? dina : rnd48();
            step();
        end
        ena = 1'b1;
        din_valid = 1'b0;
        dout_ready = 1'b1;
        repeat (12) step();
        check_drained("ena_rand");

        // Reset with three operations in flight.
        din_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dina = rnd48();
            dinb = rnd48();
            step();
        end
        din_valid = 1'b0;
        dout_ready = 1'b0;
        rst = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("flush_dout_valid_s%0d", lat_exp[i]), dout_valid_w[i], 1'b0);
            check($sformatf("flush_dout_s%0d", lat_exp[i]), dout_w[i], 49'h0);
            check($sformatf("flush_ready_s%0d", lat_exp[i]), din_ready_w[i], 1'b0);
        end
        rst = 1'b0;
        dout_ready = 1'b1;
        lat_test("after_flush", 48'h8000_0000_0000, 48'h0000_0000_0001, 49'h0_7FFF_FFFF_FFFF);
        check_drained("after_flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/math_sub_48.md
# math_sub_48

Pipelined 48-bit unsigned subtractor built in fabric. It computes `dina - dinb` and returns the 48-bit difference plus a borrow flag. It is the subtract counterpart to the 48-bit DSP/fabric adder in the math utility library, and is meant for datapaths where DSP slices are exhausted or the carry chain must be broken up for timing. The borrow chain is split into equal segments, one per pipeline stage, and a valid/ready handshake is carried through every stage.

## Interface
- `SEGMENTS`, default 4: number of pipeline stages and borrow-chain segments. Legal values are 1, 2, 3, 4, 6; segment width is 48/SEGMENTS.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ena`  in  1  global clock enable, active-high. When low, all state freezes.
- `din_valid`  in  1  operand pair valid.
- `din_ready`  out  1  block can accept an operand pair.
- `dina`  in  48  minuend, unsigned.
- `dinb`  in  48  subtrahend, unsigned.
- `dout_valid`  out  1  result valid.
- `dout_ready`  in  1  downstream accepts the result.
- `dout`  out  49  result. `dout[47:0]` = (dina − dinb) mod 2^48; `dout[48]` = borrow, 1 iff dina < dinb.

## Operation
- A transfer occurs at a rising edge with `ena && din_valid && din_ready` (input) or `ena && dout_valid && dout_ready` (output).
- Stage k (0..SEGMENTS−1) holds:
  - a valid bit;
  - difference bits for segments 0..k (already resolved);
  - the unprocessed upper operand bits;
  - the borrow out of segment k.
- Stage k computes segment k as `a_seg − b_seg − borrow_in`.
  - Stage 0 uses `borrow_in = 0`.
  - Each stage is implemented as `a_seg + ~b_seg + !borrow_in`; `borrow_out = !carry_out`.
- The final stage's registers drive `dout` and `dout_valid` directly. The borrow of the last segment is `dout[48]`.
- Stage advance rule: stage k loads from stage k−1 (or from the input, for k=0) when `ena` and (stage k is empty, or stage k advances this cycle).
  - The last stage "advances" when `dout_ready`.
  - The ready chain is combinational back to `din_ready`. There is no skid buffer.
- `din_ready = ena && !rst && (!stage0_valid || stage0_advances)`.
- A stalled stage holds all of its data bits unchanged.
- Bubbles compress: an empty stage accepts new data even if later stages are stalled.
- `ena` low:
  - no transfer occurs;
  - `din_ready` = 0;
  - `dout_valid` and `dout` keep their values.
- Reset:
  - all valid bits = 0, `dout` = 0, `dout_valid` = 0, `din_ready` = 0 while `rst` is high;
  - data in flight is discarded, with no partial output;
  - `din_ready` = 1 on the first cycle after reset with `ena` high.
- Width rule: no sign interpretation. Signed users read `dout[47:0]` as the two's-complement difference and ignore `dout[48]`.

## Timing
- Latency: SEGMENTS cycles from input transfer to `dout_valid`, with no stall. SEGMENTS=1 gives a single registered stage.
- Throughput: 1 result/cycle while `dout_ready` is held high.
- Ordering is strictly in order. The block holds at most SEGMENTS results in flight.
- `dout` is stable while `dout_valid && !dout_ready`.
- Critical path: one segment carry chain plus the ready-chain AND of SEGMENTS terms.

## Structure
- Shared package `math_pkg`:
  - `MATH_W = 48`;
  - a function `math_seg_w(SEGMENTS)`;
  - the legal-SEGMENTS check, used by an elaboration-time assertion.
- Sub-module `math_sub_seg`: one segment stage. It contains the valid bit, hold logic, segment subtract, borrow register, and a pass-through of upper operands and lower results. The top level instantiates it in a generate loop.

## Test plan
- Reset then single op, `dout_ready`=1: dina=48'h0000_0000_0005, dinb=48'h0000_0000_0003 → `dout`=49'h0_0000_0000_0002 exactly 4 cycles later; `dout_valid` high for 1 cycle.
- Borrow across every segment: dina=0, dinb=1 → `dout`=49'h1_FFFF_FFFF_FFFF. Also dina=48'h0000_0100_0000, dinb=1 → 49'h0_0000_00FF_FFFF.
- Back-to-back stream of 100 random pairs with `dout_ready`=1 → 100 results in order, one per cycle, each matching the reference model `{dina<dinb, dina-dinb}`.
- Backpressure: `dout_ready`=0 for 10 cycles while `din_valid`=1 → exactly 4 accepted, then `din_ready`=0 and `dout` stable. On release, the 4 results drain in order and no data is lost or duplicated.
- `ena` toggled pseudo-randomly with random `din_valid`/`dout_ready` → outputs match the model. No transfer occurs on any cycle with `ena`=0.
- `rst` asserted with 3 ops in flight → `dout_valid`=0 and `dout`=0 the next cycle. The in-flight ops never appear, and new ops after reset complete with 4-cycle latency. Repeat with SEGMENTS=1 and SEGMENTS=6 (latency 1 and 6).
